bist_sig_ctrl: RTL and testbench
================================

# bist_sig_ctrl

BIST controller and response compactor sitting directly downstream of the 9-bit pattern LFSR. On `start` it seeds the LFSR, then steps it for a programmed number of patterns. It compacts the circuit-under-test response for each pattern into a multiple-input signature register (MISR), compares the final signature against a golden value, and reports pass/fail.

## Interface
- `RESP_W`, 9, width of CUT response and of the MISR.
- `PAT_COUNT`, 511, number of patterns applied (≥1); pattern 0 is the LFSR seed.
- `POLY`, 9'h012, MISR feedback tap mask (bit i set ⇒ sig[i] in feedback XOR).
- `GOLDEN`, 9'h000, expected final signature.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `start` in 1: run request, sampled only in IDLE or DONE.
- `resp` in RESP_W: CUT response to current LFSR pattern, combinational from LFSR state.
- `lfsr_reset` out 1: drives LFSR synchronous reset (loads seed).
- `lfsr_en` out 1: drives LFSR enable.
- `busy` out 1: high in SEED, RUN, CMP.
- `done` out 1: high in DONE.
- `pass` out 1: registered compare result, valid while `done`=1.
- `signature` out RESP_W: current MISR contents.

## Operation
- States: IDLE, SEED, RUN, CMP, DONE.
- IDLE: outputs quiet. `start`=1 → SEED.
- SEED, 1 cycle:
  - `lfsr_reset`=1.
  - MISR ← 0, pattern counter ← 0, `pass` ← 0.
  - Next state RUN.
- RUN:
  - `lfsr_en`=1.
  - Each edge: MISR ← next, counter ← counter+1.
  - Edge with counter == PAT_COUNT−1 → CMP.
- MISR next:
  - For i < RESP_W−1: next[i] = sig[i+1] ^ resp[i].
  - next[RESP_W−1] = (^(sig & POLY)) ^ resp[RESP_W−1].
- CMP, 1 cycle: `pass` ← (signature == GOLDEN); next state DONE. `lfsr_en`=0, so the LFSR holds.
- DONE: `done`=1; `pass` and `signature` held. `start`=1 → SEED (restart); otherwise stay.
- `start` in SEED/RUN/CMP is ignored.
- Counter width: $clog2(PAT_COUNT+1); no wrap occurs within a run.
- `lfsr_reset` and `lfsr_en` are decoded from state and are never high together.
- Reset values: state IDLE; MISR 0; counter 0. All outputs 0 (`signature` = 0).
- Reset mid-run: immediate return to IDLE, results discarded. The LFSR is not reseeded until the next SEED.

## Timing
- Edge E0 samples `start` → SEED in cycle 1. E1: LFSR loads seed, state RUN.
- E2..E(PAT_COUNT+1): MISR captures resp of patterns 0..PAT_COUNT−1.
- E(PAT_COUNT+1) → CMP. E(PAT_COUNT+2) → DONE, with `pass` valid.
- Start-to-done latency: PAT_COUNT+2 edges. `busy` is high for exactly PAT_COUNT+2 cycles.
- `start` held high continuously: a new run begins the cycle after DONE is entered, so `done` pulses for 1 cycle per run.

## Configuration
- `BIST_SIG_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort`=1 in SEED/RUN/CMP → IDLE on the next edge, with `pass`=0 and `done`=0.
  - `abort` has priority over counter completion.
  - `abort` in IDLE/DONE is ignored.
- Undefined: no `abort` port; runs always complete.

## Test plan
- PAT_COUNT=4, GOLDEN=0, `resp`=0 constant, pulse `start` → `busy` high 6 cycles, then `done`=1, `pass`=1, `signature`=0x000.
- PAT_COUNT=4, GOLDEN=0x1E0, `resp`=9'h100 constant → MISR sequence 0x100, 0x180, 0x1C0, 0x1E0; `pass`=1. Same run with GOLDEN=0x1E1 → `pass`=0.
- Connect the real LFSR (seed 28), PAT_COUNT=511 → exactly 1 `lfsr_reset` cycle and 511 `lfsr_en` cycles; LFSR state at DONE equals its 511th successor of 28.
- Assert `reset` low mid-RUN (counter=2) → same cycle: state IDLE, `busy`=0, `signature`=0. A new `start` completes normally with the correct signature.
- `start` pulsed during RUN is ignored. `start` held high through DONE → restart into SEED the next cycle; `done` high exactly 1 cycle.
- With `BIST_SIG_ABORT_EN`, `abort` at counter=1 → IDLE next cycle, `done` never asserts, `pass`=0.

Source files
------------

// File: rtl/bist_sig_ctrl.sv
// rtl/bist_sig_ctrl.sv - BIST sequencer with MISR response compaction and golden compare.
// Optional abort input enabled by defining BIST_SIG_ABORT_EN.
module bist_sig_ctrl #(
  parameter int                RESP_W    = 9,
  parameter int                PAT_COUNT = 511,
  parameter logic [RESP_W-1:0] POLY      = 9'h012,
  parameter logic [RESP_W-1:0] GOLDEN    = 9'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef BIST_SIG_ABORT_EN
  input  logic              abort,
`endif
  input  logic [RESP_W-1:0] resp,
  output logic              lfsr_reset,
  output logic              lfsr_en,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [RESP_W-1:0] signature
);

  localparam int CNT_W = $clog2(PAT_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_PAT = CNT_W'(PAT_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEED = 3'd1,
    RUN  = 3'd2,
    CMP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  pat_cnt;
  logic [RESP_W-1:0] sig;
  logic [RESP_W-1:0] sig_nxt;
  logic              pass_q;
  logic              abort_hit;

  // Shift toward bit 0; the top bit takes the tapped parity of the old signature.
  assign sig_nxt = {(^(sig & POLY)) ^ resp[RESP_W-1],
                    sig[RESP_W-1:1] ^ resp[RESP_W-2:0]};

`ifdef BIST_SIG_ABORT_EN
  assign abort_hit = abort && (state == SEED || state == RUN || state == CMP);
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEED;
      SEED:    state_nxt = RUN;
      RUN:     if (pat_cnt == LAST_PAT) state_nxt = CMP;
      CMP:     state_nxt = DONE;
      DONE:    if (start) state_nxt = SEED;
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sig     <= '0;
      pat_cnt <= '0;
      pass_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        SEED: begin
          sig     <= '0;
          pat_cnt <= '0;
          pass_q  <= 1'b0;
        end
        RUN: begin
          sig     <= sig_nxt;
          pat_cnt <= pat_cnt + 1'b1;
        end
        CMP:     pass_q <= (sig == GOLDEN);
        default: ;
      endcase
      if (abort_hit) pass_q <= 1'b0;
    end
  end

  assign lfsr_reset = (state == SEED);
  assign lfsr_en    = (state == RUN);
  assign busy       = (state == SEED) || (state == RUN) || (state == CMP);
  assign done       = (state == DONE);
  assign pass       = pass_q;
  assign signature  = sig;

endmodule

// File: tb/tb_bist_sig_ctrl.sv
// tb/tb_bist_sig_ctrl.sv - Bench for bist_sig_ctrl: table vectors, random responses, real LFSR run.
module tb_bist_sig_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       start_c;
  logic [8:0] resp_a;
  logic [8:0] resp_c;
`ifdef BIST_SIG_ABORT_EN
  logic       abort;
`endif

  logic       lr_a, le_a, busy_a, done_a, pass_a;
  logic [8:0] sig_a;
  logic       lr_b, le_b, busy_b, done_b, pass_b;
  logic [8:0] sig_b;
  logic       lr_c, le_c, busy_c, done_c, pass_c;
  logic [8:0] sig_c;
  logic [8:0] lfsr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] q_resp[$];

  always #5 clk = ~clk;

  bist_sig_ctrl #(.RESP_W(9), .PAT_COUNT(4), .POLY(9'h012), .GOLDEN(9'h1E0)) u_a (
    .clk(clk), .reset(reset), .start(start),
`ifdef BIST_SIG_ABORT_EN
    .abort(abort),
`endif
    .resp(resp_a), .lfsr_reset(lr_a), .lfsr_en(le_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .signature(sig_a));

  bist_sig_ctrl #(.RESP_W(9), .PAT_COUNT(4), .POLY(9'h012), .GOLDEN(9'h1E1)) u_b (
    .clk(clk), .reset(reset), .start(start),
`ifdef BIST_SIG_ABORT_EN
    .abort(abort),
`endif
    .resp(resp_a), .lfsr_reset(lr_b), .lfsr_en(le_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .signature(sig_b));

  bist_sig_ctrl #(.RESP_W(9), .PAT_COUNT(511), .POLY(9'h012), .GOLDEN(9'h000)) u_c (
    .clk(clk), .reset(reset), .start(start_c),
`ifdef BIST_SIG_ABORT_EN
    .abort(abort),
`endif
    .resp(resp_c), .lfsr_reset(lr_c), .lfsr_en(le_c), .busy(busy_c),
    .done(done_c), .pass(pass_c), .signature(sig_c));

  // Pattern LFSR x^9 + x^5 + 1 and a stand-in combinational circuit under test.
  function automatic logic [8:0] lfsr_step(input logic [8:0] s);
    return {s[7:0], s[8] ^ s[4]};
  endfunction

  function automatic logic [8:0] cut_fn(input logic [8:0] s);
    return s ^ {s[0], s[8:1]} ^ 9'h0A5;
  endfunction

  always @(posedge clk) begin
    if (lr_c)      lfsr <= 9'd28;
    else if (le_c) lfsr <= lfsr_step(lfsr);
  end
  assign resp_c = cut_fn(lfsr);

  // Reference compaction: divide-by-two shift plus tapped parity into the MSB.
  function automatic logic [8:0] ref_step(input logic [8:0] s, input logic [8:0] r);
    int fb;
    fb = $countones(s & 9'h012) % 2;
    return 9'((int'(s) / 2) + fb * 256) ^ r;
  endfunction

  function automatic logic [8:0] model_sig();
    logic [8:0] s = '0;
    foreach (q_resp[i]) s = ref_step(s, q_resp[i]);
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One PAT_COUNT=4 run on u_a/u_b; responses captured in RUN are logged to q_resp.
  task automatic run_ab(input bit rnd, input logic [8:0] cval, output int cyc);
    logic [8:0] r;
    q_resp.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (busy_a && cyc < 20) begin
      if (le_a) begin
        r = rnd ? 9'($urandom) : cval;
        resp_a = r;
        q_resp.push_back(r);
        start = rnd && ($urandom_range(0, 2) == 0);
      end else begin
        resp_a = 9'($urandom);
        start = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [8:0] resp;
    logic [8:0] sig;
    logic       pa;
    logic       pb;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int cyc, nrst, nen, nbusy, both, ndone;
    logic [8:0] exp_l, exp_s;

    tbl[0] = '{9'h000, 9'h000, 1'b0, 1'b0};
    tbl[1] = '{9'h100, 9'h1E0, 1'b1, 1'b0};
    tbl[2] = '{9'h001, 9'h001, 1'b0, 1'b0};
    tbl[3] = '{9'h1FF, 9'h140, 1'b0, 1'b0};

    reset = 1'b0; start = 1'b0; start_c = 1'b0; resp_a = '0;
`ifdef BIST_SIG_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_outputs_a", {lr_a, le_a, busy_a, done_a, pass_a, sig_a}, 0);
    chk("rst_outputs_c", {lr_c, le_c, busy_c, done_c, pass_c, sig_c}, 0);
    reset = 1'b1;

    // MISR trace with constant 0x100 response.
    @(negedge clk); start = 1'b1; resp_a = 9'h100;
    @(negedge clk); start = 1'b0;
    chk("seed_lfsr_reset", {lr_a, le_a, busy_a, sig_a}, {1'b1, 1'b0, 1'b1, 9'h000});
    @(negedge clk); chk("run0_sig", {le_a, sig_a}, {1'b1, 9'h000});
    @(negedge clk); chk("run1_sig", sig_a, 9'h100);
    @(negedge clk); chk("run2_sig", sig_a, 9'h180);
    @(negedge clk); chk("run3_sig", sig_a, 9'h1C0);
    @(negedge clk); chk("cmp_sig", {busy_a, le_a, sig_a}, {1'b1, 1'b0, 9'h1E0});
    @(negedge clk); chk("done_trace", {busy_a, done_a, pass_a, pass_b}, 4'b0110);

    for (int i = 0; i < 4; i++) begin
      run_ab(1'b0, tbl[i].resp, cyc);
      chk($sformatf("tbl%0d_busy", i), cyc, 6);
      chk($sformatf("tbl%0d_done", i), done_a, 1);
      chk($sformatf("tbl%0d_sig", i), sig_a, tbl[i].sig);
      chk($sformatf("tbl%0d_pass", i), {pass_a, pass_b}, {tbl[i].pa, tbl[i].pb});
    end

    for (int i = 0; i < 6; i++) begin
      run_ab(1'b1, 9'h0, cyc);
      exp_s = model_sig();
      chk($sformatf("rnd%0d_busy", i), cyc, 6);
      chk($sformatf("rnd%0d_npat", i), q_resp.size(), 4);
      chk($sformatf("rnd%0d_sig", i), {sig_a, sig_b}, {exp_s, exp_s});
      chk($sformatf("rnd%0d_pass", i), {pass_a, pass_b},
          {exp_s == 9'h1E0, exp_s == 9'h1E1});
      @(negedge clk);
      chk($sformatf("rnd%0d_hold", i), {done_a, sig_a}, {1'b1, exp_s});
    end

    // Reset asserted while RUN counter is 2.
    @(negedge clk); start = 1'b1; resp_a = 9'h1FF;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_clear", {busy_a, done_a, le_a, lr_a, sig_a}, 0);
    @(negedge clk); reset = 1'b1;
    run_ab(1'b0, 9'h100, cyc);
    chk("post_rst_busy", cyc, 6);
    chk("post_rst_sig", {sig_a, pass_a}, {9'h1E0, 1'b1});

    // start held high: DONE lasts one cycle, then SEED.
    @(negedge clk); start = 1'b1;
    cyc = 0;
    while (!done_a && cyc < 20) begin @(negedge clk); cyc++; end
    chk("held_done_seen", done_a, 1);
    @(negedge clk);
    chk("held_restart", {done_a, lr_a, busy_a}, 3'b011);
    start = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 20) begin @(negedge clk); cyc++; end
    chk("held_second_done", done_a, 1);

    // Full-length run against the real LFSR.
    exp_l = 9'd28;
    q_resp.delete();
    for (int p = 0; p < 511; p++) begin
      q_resp.push_back(cut_fn(exp_l));
      exp_l = lfsr_step(exp_l);
    end
    exp_s = model_sig();
    @(negedge clk); start_c = 1'b1;
    @(negedge clk); start_c = 1'b0;
    nrst = 0; nen = 0; nbusy = 0; both = 0; cyc = 0;
    while (!done_c && cyc < 600) begin
      nrst += int'(lr_c);
      nen += int'(le_c);
      nbusy += int'(busy_c);
      both += int'(lr_c & le_c);
      @(negedge clk); cyc++;
    end
    chk("lfsr_reset_cycles", nrst, 1);
    chk("lfsr_en_cycles", nen, 511);
    chk("full_busy_cycles", nbusy, 513);
    chk("never_both", both, 0);
    chk("lfsr_final", lfsr, exp_l);
    chk("lfsr_full_period", lfsr, 9'd28);
    chk("full_sig", {done_c, sig_c}, {1'b1, exp_s});
    chk("full_pass", pass_c, exp_s == 9'h000);

`ifdef BIST_SIG_ABORT_EN
    @(negedge clk); start = 1'b1; resp_a = 9'h100;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_idle", {busy_a, done_a, pass_a}, 3'b000);
    ndone = 0;
    repeat (8) begin @(negedge clk); ndone += int'(done_a | busy_a); end
    chk("abort_no_done", ndone, 0);
`else
    ndone = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
